ctrl_pipeline: RTL

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipeline_pkg.sv | 57 +++++
 rtl/ctrl_pipeline_hazard_unit.sv | 68 ++++++
 rtl/ctrl_pipeline.sv | 110 +++++++++++
 3 files changed

// File: rtl/ctrl_pipeline_pkg.sv
// Shared controller constants and stage bundles for ctrl_pipeline.
// CTRL_FWD_EN selects forwarding; otherwise RAW hazards stall.
package ctrl_pipeline_pkg;

    localparam int CB_ALUSRC   = 0;
    localparam int CB_REGDST   = 1;
    localparam int CB_REGWRITE = 2;
    localparam int CB_WRITEMEM = 3;
    localparam int CB_READMEM  = 4;
    localparam int CB_MEMTOREG = 5;
    localparam int CB_SHIFT    = 6;

    localparam int MB_REGWRITE = 0;
    localparam int MB_WRITEMEM = 1;
    localparam int MB_READMEM  = 2;
    localparam int MB_MEMTOREG = 3;

    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic [3:0] aluop;
        logic [6:0] ctrl;
        logic [4:0] dest;
    } id_ex_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic [4:0] dest;
    } ex_mem_t;

    typedef struct packed {
        logic [1:0] ctrl;
        logic [4:0] dest;
    } mem_wb_t;

    localparam id_ex_t EX_BUBBLE = '{aluop: ALU_NOP, ctrl: 7'd0, dest: 5'd0};

    // $0 is hardwired, so it never matches anything
    function automatic logic reg_hit(input logic [4:0] dst,
                                     input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/ctrl_pipeline_hazard_unit.sv
// Hazard detection and operand-forward selection for ctrl_pipeline.
// CTRL_FWD_EN: forward from MEM/WB, stall only on load-use.
module hazard_unit
    import ctrl_pipeline_pkg::*;
(
    input  logic       i_id_valid,
    input  logic       i_flush,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic [4:0] i_ex_dest,
    input  logic       i_mem_regwrite,
    input  logic [4:0] i_mem_dest,
    output logic       o_stall
`ifdef CTRL_FWD_EN
    ,
    input  logic       i_ex_readmem,
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_ex_rt,
    input  logic       i_wb_regwrite,
    input  logic [4:0] i_wb_dest,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
`else
    ,
    input  logic       i_ex_regwrite
`endif
);

    logic w_raw;

`ifdef CTRL_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       mem_rw,
                                           input logic [4:0] mem_dst,
                                           input logic       wb_rw,
                                           input logic [4:0] wb_dst);
        if (mem_rw && reg_hit(mem_dst, src))
            return FWD_MEM;
        else if (wb_rw && reg_hit(wb_dst, src))
            return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        w_raw = i_id_valid && i_ex_readmem &&
                (reg_hit(i_ex_dest, i_id_rs) || reg_hit(i_ex_dest, i_id_rt));
        o_fwd_a = fwd_sel(i_ex_rs, i_mem_regwrite, i_mem_dest,
                          i_wb_regwrite, i_wb_dest);
        o_fwd_b = fwd_sel(i_ex_rt, i_mem_regwrite, i_mem_dest,
                          i_wb_regwrite, i_wb_dest);
    end
`else
    logic w_ex_hit;
    logic w_mem_hit;

    always_comb begin
        w_ex_hit  = i_ex_regwrite &&
                    (reg_hit(i_ex_dest, i_id_rs) || reg_hit(i_ex_dest, i_id_rt));
        w_mem_hit = i_mem_regwrite &&
                    (reg_hit(i_mem_dest, i_id_rs) || reg_hit(i_mem_dest, i_id_rt));
        w_raw     = i_id_valid && (w_ex_hit || w_mem_hit);
    end
`endif

    // a taken branch kills the ID instruction, so there is nothing to hold
    assign o_stall = w_raw && !i_flush;

endmodule

// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control registers with hazard stall and optional forwarding.
// CTRL_FWD_EN adds fwd_a/fwd_b and relaxes stalls to load-use only.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [3:0] id_aluop,
    input  logic [6:0] id_ctrl,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       flush,
    output logic       stall,
    output logic [3:0] ex_aluop,
    output logic [6:0] ex_ctrl,
    output logic [4:0] ex_dest,
    output logic [3:0] mem_ctrl,
    output logic [4:0] mem_dest,
    output logic [1:0] wb_ctrl,
    output logic [4:0] wb_dest
`ifdef CTRL_FWD_EN
    ,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
`endif
);

    id_ex_t  r_ex;
    ex_mem_t r_mem;
    mem_wb_t r_wb;
    id_ex_t  w_ex_next;
    logic    w_stall;
    logic    w_take;

    assign w_take = id_valid && !w_stall && !flush;

    always_comb begin
        w_ex_next = EX_BUBBLE;
        if (w_take) begin
            w_ex_next.aluop = id_aluop;
            w_ex_next.ctrl  = id_ctrl;
            w_ex_next.dest  = id_ctrl[CB_REGDST] ? id_rd : id_rt;
        end
    end

    // MEM/WB always advance; a stall only bubbles EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= EX_BUBBLE;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex       <= w_ex_next;
            r_mem.ctrl <= {r_ex.ctrl[CB_MEMTOREG], r_ex.ctrl[CB_READMEM],
                           r_ex.ctrl[CB_WRITEMEM], r_ex.ctrl[CB_REGWRITE]};
            r_mem.dest <= r_ex.dest;
            r_wb.ctrl  <= {r_mem.ctrl[MB_MEMTOREG], r_mem.ctrl[MB_REGWRITE]};
            r_wb.dest  <= r_mem.dest;
        end
    end

`ifdef CTRL_FWD_EN
    logic [4:0] r_ex_rs;
    logic [4:0] r_ex_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rs <= 5'd0;
            r_ex_rt <= 5'd0;
        end else begin
            r_ex_rs <= w_take ? id_rs : 5'd0;
            r_ex_rt <= w_take ? id_rt : 5'd0;
        end
    end
`endif

    hazard_unit u_hazard (
        .i_id_valid     (id_valid),
        .i_flush        (flush),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_ex_dest      (r_ex.dest),
        .i_mem_regwrite (r_mem.ctrl[MB_REGWRITE]),
        .i_mem_dest     (r_mem.dest),
        .o_stall        (w_stall),
`ifdef CTRL_FWD_EN
        .i_ex_readmem   (r_ex.ctrl[CB_READMEM]),
        .i_ex_rs        (r_ex_rs),
        .i_ex_rt        (r_ex_rt),
        .i_wb_regwrite  (r_wb.ctrl[WB_REGWRITE]),
        .i_wb_dest      (r_wb.dest),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b)
`else
        .i_ex_regwrite  (r_ex.ctrl[CB_REGWRITE])
`endif
    );

    assign stall    = w_stall;
    assign ex_aluop = r_ex.aluop;
    assign ex_ctrl  = r_ex.ctrl;
    assign ex_dest  = r_ex.dest;
    assign mem_ctrl = r_mem.ctrl;
    assign mem_dest = r_mem.dest;
    assign wb_ctrl  = r_wb.ctrl;
    assign wb_dest  = r_wb.dest;

endmodule
